// File: rtl/rf_val_sweep_ctrl_if.sv
// Command/config and RF-cell signal bundle for the RF validation sweep sequencer.
// Optional pass_cnt output exists only when RF_SWEEP_PASSCNT_EN is defined.
interface rf_val_sweep_ctrl_if #(
  parameter int unsigned N_CH = 8,
  parameter int unsigned DW_W = 16
);
  localparam int unsigned IdxW = $clog2(N_CH);

  logic              start;
  logic              stop;
  logic [N_CH-1:0]   ch_mask;
  logic [DW_W-1:0]   dwell;
  logic              loop;
  logic [N_CH-1:0]   sel;
  logic              en;
  logic [IdxW-1:0]   ch_idx;
  logic              busy;
  logic              mark;
  logic              done;
`ifdef RF_SWEEP_PASSCNT_EN
  logic [7:0]        pass_cnt;

  modport master (
    output start, stop, ch_mask, dwell, loop,
    input  sel, en, ch_idx, busy, mark, done, pass_cnt
  );
  modport slave (
    input  start, stop, ch_mask, dwell, loop,
    output sel, en, ch_idx, busy, mark, done, pass_cnt
  );
`else
  modport master (
    output start, stop, ch_mask, dwell, loop,
    input  sel, en, ch_idx, busy, mark, done
  );
  modport slave (
    input  start, stop, ch_mask, dwell, loop,
    output sel, en, ch_idx, busy, mark, done
  );
`endif
endinterface

// File: rtl/rf_val_sweep_ctrl.sv
// Sweep sequencer for RF validation cells: per enabled channel, settle with en low, then dwell.
// Optional feature: RF_SWEEP_PASSCNT_EN adds a saturating pass counter output.
module rf_val_sweep_ctrl #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DW_W   = 16,
  parameter int unsigned SETTLE = 4
) (
  input logic               clk,
  input logic               rst,
  rf_val_sweep_ctrl_if.slave bus
);
  localparam int unsigned IdxW = $clog2(N_CH);
  // Search pointer can hold N_CH, meaning "past the last channel".
  localparam int unsigned PtrW = $clog2(N_CH + 1);
  localparam int unsigned SetW = $clog2(SETTLE + 1);
  localparam int unsigned CntW = (DW_W > SetW) ? DW_W : SetW;

  typedef enum logic [2:0] {StIdle, StSeek, StSettle, StDwell, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   mask_q;
  logic [DW_W-1:0]   dwell_last_q;
  logic              loop_q;
  logic [PtrW-1:0]   ptr_q;
  logic [CntW-1:0]   cnt_q;

  logic [N_CH-1:0]   sel_q, sel_d;
  logic              en_q, en_d;
  logic [IdxW-1:0]   ch_idx_q, ch_idx_d;
  logic              busy_q, busy_d;
  logic              mark_q, mark_d;
  logic              done_q, done_d;

  logic              accept;
  logic              hit;
  logic [IdxW-1:0]   hit_idx;
  logic [IdxW-1:0]   low_idx;
  logic [IdxW-1:0]   pick_idx;
  logic              settle_end;
  logic              dwell_end;

  // Lowest enabled channel at or above the pointer, and lowest enabled channel overall.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_idx = IdxW'(i);
        if (PtrW'(i) >= ptr_q) begin
          hit     = 1'b1;
          hit_idx = IdxW'(i);
        end
      end
    end
    pick_idx = hit ? hit_idx : low_idx;
  end

  assign accept     = (state_q == StIdle) && bus.start && !bus.stop;
  assign settle_end = (cnt_q == CntW'(SETTLE - 1));
  assign dwell_end  = (cnt_q == CntW'(dwell_last_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (|bus.ch_mask) ? StSeek : StDone;
        end
      end
      StSeek: begin
        if (hit || loop_q) begin
          state_d = StSettle;
        end else begin
          state_d = StDone;
        end
      end
      StSettle: begin
        if (settle_end) begin
          state_d = StDwell;
        end
      end
      StDwell: begin
        if (dwell_end) begin
          state_d = StSeek;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.stop && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  // Config latch, search pointer and the shared settle/dwell counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q       <= '0;
      dwell_last_q <= '0;
      loop_q       <= 1'b0;
      ptr_q        <= '0;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        mask_q       <= bus.ch_mask;
        dwell_last_q <= (bus.dwell == '0) ? '0 : bus.dwell - DW_W'(1);
        loop_q       <= bus.loop;
        ptr_q        <= '0;
      end else if ((state_q == StDwell) && (state_d == StSeek)) begin
        ptr_q <= PtrW'(ch_idx_q) + PtrW'(1);
      end
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((state_q == StSettle) || (state_q == StDwell)) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    sel_d    = sel_q;
    ch_idx_d = ch_idx_q;
    if ((state_q == StSeek) && (state_d == StSettle)) begin
      sel_d    = N_CH'(1) << pick_idx;
      ch_idx_d = pick_idx;
    end else if ((state_d == StIdle) || (state_d == StDone)) begin
      sel_d = '0;
    end
    en_d   = (state_d == StDwell);
    mark_d = (state_d == StDwell) && (state_q != StDwell);
    done_d = (state_d == StDone);
    busy_d = (state_d == StSeek) || (state_d == StSettle) || (state_d == StDwell);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      en_q     <= 1'b0;
      ch_idx_q <= '0;
      busy_q   <= 1'b0;
      mark_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      en_q     <= en_d;
      ch_idx_q <= ch_idx_d;
      busy_q   <= busy_d;
      mark_q   <= mark_d;
      done_q   <= done_d;
    end
  end

  assign bus.sel    = sel_q;
  assign bus.en     = en_q;
  assign bus.ch_idx = ch_idx_q;
  assign bus.busy   = busy_q;
  assign bus.mark   = mark_q;
  assign bus.done   = done_q;

`ifdef RF_SWEEP_PASSCNT_EN
  logic [7:0] pass_cnt_q;

  // A pass completes whenever a seek runs off the end of the mask (wrap or finish).
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt_q <= '0;
    end else if (accept) begin
      pass_cnt_q <= '0;
    end else if ((state_q == StSeek) && !hit && (state_d != StIdle) &&
                 (pass_cnt_q != 8'hFF)) begin
      pass_cnt_q <= pass_cnt_q + 8'd1;
    end
  end

  assign bus.pass_cnt = pass_cnt_q;
`endif
endmodule

// File: tb/tb_rf_val_sweep_ctrl.sv
// Self-checking bench for rf_val_sweep_ctrl: directed table, hand sequences, random sweeps.
module tb_rf_val_sweep_ctrl;
  localparam int unsigned N_CH   = 8;
  localparam int unsigned DW_W   = 16;
  localparam int unsigned SETTLE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_val_sweep_ctrl_if #(.N_CH(N_CH), .DW_W(DW_W)) bus ();

  rf_val_sweep_ctrl #(.N_CH(N_CH), .DW_W(DW_W), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] sel;
    logic       en;
    logic [2:0] ch;
    logic       busy;
    logic       mark;
    logic       done;
  } obs_t;

  typedef struct {
    logic [7:0] mask;
    int         dwell;
    bit         lp;
    int         stop_at;
    int         run;
    int         done_at;
    int         en_cnt;
    int         marks;
  } vec_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_ch     = 0;

  function automatic obs_t mk(int sel, bit en, int ch, bit busy, bit mark, bit done);
    obs_t o;
    o.sel  = 8'(sel);
    o.en   = en;
    o.ch   = 3'(ch);
    o.busy = busy;
    o.mark = mark;
    o.done = done;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(int'(bus.sel), bus.en, int'(bus.ch_idx), bus.busy, bus.mark, bus.done);
  endfunction

  task automatic check_obs(input string name, input int cyc, input obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got sel=%h en=%b ch=%0d busy=%b mark=%b done=%b, want sel=%h en=%b ch=%0d busy=%b mark=%b done=%b",
               name, cyc, act.sel, act.en, act.ch, act.busy, act.mark, act.done,
               exp.sel, exp.en, exp.ch, exp.busy, exp.mark, exp.done);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs for a sweep started at cycle 0; entry k is cycle k+1.
  task automatic build_trace(input logic [7:0] mask, input int dwell, input bit lp,
                             input int maxlen);
    int chans[$];
    int d;
    int k;
    int c;
    int mc;
    int cur_sel;
    exp_q.delete();
    d  = (dwell == 0) ? 1 : dwell;
    mc = m_ch;
    for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
    if (chans.size() == 0) begin
      exp_q.push_back(mk(0, 0, mc, 0, 0, 1));
    end else begin
      exp_q.push_back(mk(0, 0, mc, 1, 0, 0));
      k = 0;
      while (exp_q.size() < maxlen) begin
        c       = chans[k];
        mc      = c;
        cur_sel = 1 << c;
        for (int s = 0; s < SETTLE; s++) exp_q.push_back(mk(cur_sel, 0, c, 1, 0, 0));
        for (int j = 0; j < d; j++) exp_q.push_back(mk(cur_sel, 1, c, 1, j == 0, 0));
        exp_q.push_back(mk(cur_sel, 0, c, 1, 0, 0));
        k++;
        if (k == chans.size()) begin
          if (!lp) begin
            exp_q.push_back(mk(0, 0, c, 0, 0, 1));
            break;
          end
          k = 0;
        end
      end
    end
    while (exp_q.size() < maxlen) exp_q.push_back(mk(0, 0, mc, 0, 0, 0));
  endtask

  // Starts a sweep now (cycle 0), scrambles config inputs afterwards, compares every cycle.
  task automatic run_sweep(input string name, input logic [7:0] mask, input int dwell,
                           input bit lp, input int stop_at, input int poke_at, input int ncyc,
                           output int en_cnt, output int marks, output int done_at);
    obs_t exp;
    int   stop_ch;
    build_trace(mask, dwell, lp, ncyc);
    en_cnt      = 0;
    marks       = 0;
    done_at     = -1;
    stop_ch     = 0;
    exp         = exp_q[0];
    bus.start   = 1'b1;
    bus.stop    = 1'b0;
    bus.ch_mask = mask;
    bus.dwell   = 16'(dwell);
    bus.loop    = lp;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      tick();
      bus.stop  = 1'b0;
      bus.start = (cyc == poke_at);
      if (cyc == poke_at) begin
        bus.ch_mask = 8'hFF;
        bus.dwell   = 16'd9;
        bus.loop    = 1'b1;
      end else begin
        bus.ch_mask = 8'($urandom);
        bus.dwell   = 16'($urandom_range(0, 20));
        bus.loop    = 1'($urandom);
      end
      if (stop_at > 0 && cyc > stop_at) exp = mk(0, 0, stop_ch, 0, 0, 0);
      else exp = exp_q[cyc-1];
      if (cyc == stop_at) begin
        stop_ch  = int'(exp.ch);
        bus.stop = 1'b1;
      end
      check_obs(name, cyc, exp);
      en_cnt += int'(bus.en);
      marks  += int'(bus.mark);
      if (bus.done && done_at < 0) done_at = cyc;
    end
    bus.stop = 1'b0;
    m_ch     = int'(exp.ch);
  endtask

  vec_t vecs[7];

  initial begin
    int en_cnt, marks, done_at;
    logic [7:0] rmask;
    bit rlp;
    int rn, rstop;

    vecs[0] = '{8'h05, 3, 1'b0, 0,  21, 18, 6, 2};
    vecs[1] = '{8'h00, 5, 1'b0, 0,   4,  1, 0, 0};
    vecs[2] = '{8'h02, 0, 1'b0, 0,  11,  8, 1, 1};
    vecs[3] = '{8'h80, 1, 1'b0, 0,  11,  8, 1, 1};
    vecs[4] = '{8'hFF, 1, 1'b0, 0,  53, 50, 8, 8};
    vecs[5] = '{8'h81, 2, 1'b0, 0,  19, 16, 4, 2};
    vecs[6] = '{8'h80, 2, 1'b1, 40, 44, -1, 10, 5};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.ch_mask = '0;
    bus.dwell   = '0;
    bus.loop    = 1'b0;
    tick();
    tick();
    check_obs("reset", 0, mk(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    tick();

    foreach (vecs[v]) begin
      run_sweep($sformatf("vec%0d", v), vecs[v].mask, vecs[v].dwell, vecs[v].lp,
                vecs[v].stop_at, 0, vecs[v].run, en_cnt, marks, done_at);
      check_int($sformatf("vec%0d en_cycles", v), en_cnt, vecs[v].en_cnt);
      check_int($sformatf("vec%0d marks", v), marks, vecs[v].marks);
      check_int($sformatf("vec%0d done_at", v), done_at, vecs[v].done_at);
    end

    // Start with new config while busy must be ignored.
    run_sweep("poke", 8'h05, 3, 1'b0, 0, 4, 21, en_cnt, marks, done_at);
    check_int("poke done_at", done_at, 18);
    check_int("poke en_cycles", en_cnt, 6);

    // stop beats start in IDLE.
    bus.start   = 1'b1;
    bus.stop    = 1'b1;
    bus.ch_mask = 8'h01;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_obs("stop_beats_start", 1, mk(0, 0, m_ch, 0, 0, 0));
    tick();
    check_obs("stop_beats_start_after", 2, mk(0, 0, m_ch, 0, 0, 0));

    // Reset in the middle of a dwell.
    bus.start   = 1'b1;
    bus.ch_mask = 8'h02;
    bus.dwell   = 16'd5;
    bus.loop    = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 2; i <= 7; i++) tick();
    check_obs("pre_reset_dwell", 7, mk(8'h02, 1, 1, 1, 0, 0));
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    m_ch = 0;
    check_obs("reset_mid_dwell", 8, mk(0, 0, 0, 0, 0, 0));
    tick();
    check_obs("after_reset_idle", 9, mk(0, 0, 0, 0, 0, 0));

    for (int r = 0; r < 20; r++) begin
      rmask = 8'($urandom);
      if ($urandom_range(0, 5) == 0) rmask = 8'h00;
      rlp = 1'($urandom);
      if (rlp) begin
        rn    = $urandom_range(20, 80);
        rstop = rn - 3;
      end else begin
        rn    = 80;
        rstop = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      end
      run_sweep($sformatf("rand%0d", r), rmask, $urandom_range(0, 4), rlp, rstop, 0, rn,
                en_cnt, marks, done_at);
    end

`ifdef RF_SWEEP_PASSCNT_EN
    bus.start   = 1'b1;
    bus.ch_mask = 8'h81;
    bus.dwell   = 16'd1;
    bus.loop    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 2; i <= 40; i++) tick();
    check_int("pass_cnt three wraps", int'(bus.pass_cnt), 3);
    for (int i = 0; i < 3620; i++) tick();
    check_int("pass_cnt saturate", int'(bus.pass_cnt), 255);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.loop  = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_int("pass_cnt single pass", int'(bus.pass_cnt), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
